instr_reader_exec: RTL and testbench
====================================

# instr_reader_exec

Read-side consumer for the instruction register. On a start request it walks a range of register entries by driving `read_pointer` and capturing `instruction_word`. It executes each captured opcode on its two signed operands and presents one result per entry on a valid/ready output stream. It sits beside the instruction register in `top`, on the same `clk`, and completes the write/read loop that the testbench currently closes by hand.

## Interface
Parameters:
- `DEPTH`, 32: number of register entries; the pointer wraps modulo `DEPTH`.

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; accepted only in IDLE
- `first_ptr`  in  address_t (5)  first entry to read
- `count`  in  6  number of entries to process, 0..32
- `read_pointer`  out  address_t (5)  address to the instruction register
- `instruction_word`  in  instruction_t  word read at `read_pointer`, combinational from the register
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  64  signed result
- `res_ptr`  out  address_t  entry that produced `res_data`
- `res_err`  out  1  illegal op or divide by zero
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when a run completes

Reset is asynchronous, active-low.

## Operation
- FSM states: IDLE, FETCH, EXEC, OUT.
- **IDLE:**
  - `start`=1 with `count`>0: load `read_pointer`=`first_ptr` and `remaining`=`count`, then go to FETCH.
  - `start`=1 with `count`=0: pulse `done` next cycle and stay in IDLE.
- **FETCH:** `read_pointer` is stable. At the clock edge, latch `instruction_word` into `iw_q`, then go to EXEC.
- **EXEC:** compute from `iw_q`. At the clock edge, register `res_data`, `res_ptr`=`read_pointer` and `res_err`, set `res_valid`=1, then go to OUT.
- **OUT:** hold all outputs until `res_valid`&&`res_ready`. On the transfer edge:
  - Decrement `remaining`.
  - If `remaining` becomes 0: go to IDLE, clear `res_valid`, pulse `done`.
  - Otherwise: `read_pointer`=(`read_pointer`+1) mod `DEPTH`, clear `res_valid`, go to FETCH.
- **Arithmetic:** operands are signed 32-bit; the result is signed 64-bit.
  - ZERO → 0
  - PASSA → sext(a)
  - PASSB → sext(b)
  - ADD → sext(a)+sext(b)
  - SUB → sext(a)−sext(b)
  - MULT → full 64-bit product
  - DIV → a/b, truncated toward zero
  - MOD → a%b, sign follows the dividend
- **Errors:** `b`=0 under DIV or MOD gives `res_data`=0 and `res_err`=1. Any undefined opcode encoding gives `res_data`=0 and `res_err`=1.
- **Ignored inputs:** `start` is ignored while `busy`. `first_ptr` and `count` are sampled only on an accepted start.

## Timing
- **Reset values:** state=IDLE, `read_pointer`=0, `res_valid`=0, `res_data`=0, `res_ptr`=0, `res_err`=0, `busy`=0, `done`=0.
- **Latency:** if `start` is accepted at edge E0, `res_valid` rises after E2 (two cycles).
- **Throughput:** with `res_ready` held high, one result every 3 cycles.
- **Output stability:** outputs stay stable while `res_valid`=1 and `res_ready`=0.
- **Wrap-around:** `first_ptr`=30, `count`=4 reads 30, 31, 0, 1.
- **`done` timing:** `done` is high for exactly the one cycle after the final transfer edge. `busy` is low in that same cycle, so a new `start` is accepted in it.
- **Reset mid-run:** return immediately to IDLE, all outputs to reset values, no `done`, no partial result.

## Configuration
- `INSTR_DIV_EN` defined: DIV and MOD are implemented as specified above.
- `INSTR_DIV_EN` undefined: no divider is synthesized. DIV and MOD return `res_data`=0 and `res_err`=1; all other opcodes are unchanged.

## Structure
- In `instr_register_pkg`:
  - `opcode_t`, `operand_t`, `address_t`, `instruction_t`
  - new `result_t` (signed 64-bit)
  - new `exec_state_t` enum
- Sub-module `instr_alu`: combinational `instruction_t` → {`result_t`, err}, containing the `INSTR_DIV_EN` guard. The FSM registers its outputs in EXEC.
- Connect the DUT side through the existing `tb_ifc` by adding the result-stream signals.

## Test plan
- Load entry 0 = {ADD, 5, −7}, `start` with `first_ptr`=0, `count`=1, `res_ready`=1 → `res_valid` 2 cycles after start with `res_data`=−2, `res_ptr`=0, `res_err`=0; `done` pulses one cycle later.
- Entries 30, 31, 0 = {MULT, 0x7FFFFFFF, 2}, {SUB, −1, 1}, {PASSB, 0, 9}; `first_ptr`=30, `count`=3 → results 0xFFFFFFFE, −2, 9 with `res_ptr` 30, 31, 0.
- Entry 4 = {DIV, −7, 2}, then {MOD, −7, 2}, then {DIV, 3, 0} → −3, −1, err=1/data=0. With `INSTR_DIV_EN` undefined, all three give err=1, data=0.
- Hold `res_ready`=0 for 5 cycles with `res_valid`=1 → `res_data`, `res_ptr`, `res_err` unchanged. Raise `res_ready` → exactly one transfer.
- `start` with `count`=0 → `done` next cycle, no FETCH. `start` pulsed while `busy` → ignored, and the run length is unchanged.
- Assert `reset_n`=0 in EXEC of a 4-entry run → all outputs 0 immediately and no `done`. After release, a new run from entry 0 is correct.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side executor.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;
  typedef logic        [5:0]  count_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    OUT   = 2'd3
  } exec_state_t;

endpackage

// File: rtl/instr_reader_exec_if.sv
// Start request, register read port and result stream of instr_reader_exec.
interface instr_reader_exec_if;
  import instr_register_pkg::*;

  logic         start;
  address_t     first_ptr;
  count_t       count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  result_t      res_data;
  address_t     res_ptr;
  logic         res_err;
  logic         busy;
  logic         done;

  modport master (
    output start, first_ptr, count, instruction_word, res_ready,
    input  read_pointer, res_valid, res_data, res_ptr, res_err, busy, done
  );

  modport slave (
    input  start, first_ptr, count, instruction_word, res_ready,
    output read_pointer, res_valid, res_data, res_ptr, res_err, busy, done
  );
endinterface

// File: rtl/instr_reader_exec_alu.sv
// Combinational opcode executor. Define INSTR_DIV_EN to build the DIV/MOD
// divider; otherwise DIV and MOD report an error with a zero result.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t iw_i,
  output result_t      res_o,
  output logic         err_o
);

  result_t a_x;
  result_t b_x;

  assign a_x = {{32{iw_i.op_a[31]}}, iw_i.op_a};
  assign b_x = {{32{iw_i.op_b[31]}}, iw_i.op_b};

  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    case (iw_i.opc)
      ZERO:  res_o = '0;
      PASSA: res_o = a_x;
      PASSB: res_o = b_x;
      ADD:   res_o = a_x + b_x;
      SUB:   res_o = a_x - b_x;
      MULT:  res_o = a_x * b_x;
`ifdef INSTR_DIV_EN
      // 64-bit operands keep -2^31 / -1 from overflowing.
      DIV: begin
        if (b_x == '0) err_o = 1'b1;
        else           res_o = a_x / b_x;
      end
      MOD: begin
        if (b_x == '0) err_o = 1'b1;
        else           res_o = a_x % b_x;
      end
`else
      DIV:   err_o = 1'b1;
      MOD:   err_o = 1'b1;
`endif
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_reader_exec.sv
// Walks a range of instruction-register entries, executes each one and
// streams one result per entry over a valid/ready handshake.
module instr_reader_exec
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input logic                clk,
  input logic                reset_n,
  instr_reader_exec_if.slave bus
);

  exec_state_t  state_q;
  address_t     rp_q;
  address_t     rp_d;
  count_t       remaining_q;
  instruction_t iw_q;
  result_t      res_data_q;
  address_t     res_ptr_q;
  logic         res_err_q;
  logic         res_valid_q;
  logic         done_q;

  result_t      alu_res;
  logic         alu_err;

  instr_alu u_alu (
    .iw_i  (iw_q),
    .res_o (alu_res),
    .err_o (alu_err)
  );

  assign rp_d = (32'(rp_q) == DEPTH - 1) ? '0 : rp_q + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rp_q        <= '0;
      remaining_q <= '0;
      iw_q        <= '0;
      res_data_q  <= '0;
      res_ptr_q   <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              rp_q        <= bus.first_ptr;
              remaining_q <= bus.count;
              state_q     <= FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          iw_q    <= bus.instruction_word;
          state_q <= EXEC;
        end
        EXEC: begin
          res_data_q  <= alu_res;
          res_ptr_q   <= rp_q;
          res_err_q   <= alu_err;
          res_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            remaining_q <= remaining_q - 6'd1;
            if (remaining_q == 6'd1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              rp_q    <= rp_d;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.read_pointer = rp_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_ptr      = res_ptr_q;
  assign bus.res_err      = res_err_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_instr_reader_exec.sv
// Self-checking bench for instr_reader_exec with a transaction-level model.
module tb_instr_reader_exec;
  import instr_register_pkg::*;

  typedef struct {
    result_t  data;
    address_t ptr;
    logic     err;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_reader_exec_if ifc ();
  instruction_t mem [0:31];

  always_comb ifc.instruction_word = mem[ifc.read_pointer];

  instr_reader_exec #(.DEPTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic res_t model(instruction_t iw, address_t p);
    res_t   r;
    longint a;
    longint b;
    a = longint'(iw.op_a);
    b = longint'(iw.op_b);
    r.ptr = p; r.err = 1'b0; r.data = '0;
    case (iw.opc)
      ZERO:  r.data = 0;
      PASSA: r.data = a;
      PASSB: r.data = b;
      ADD:   r.data = a + b;
      SUB:   r.data = a - b;
      MULT:  r.data = a * b;
`ifdef INSTR_DIV_EN
      DIV:   if (b == 0) r.err = 1'b1; else r.data = a / b;
      MOD:   if (b == 0) r.err = 1'b1; else r.data = a % b;
`endif
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Model state: what the DUT must show in the coming cycle.
  res_t exp_q[$];
  res_t log_q[$];
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic m_valid = 1'b0;
  int   m_cd = 0;
  int   done_cnt = 0;
  logic nd;
  res_t e;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", ifc.res_valid, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_data", ifc.res_data, 0);
      exp_q.delete();
      m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_cd = 0;
    end else begin
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_valid = 1'b1;
      end
      chk("valid", ifc.res_valid, m_valid);
      chk("busy", ifc.busy, m_busy);
      chk("done", ifc.done, m_done);
      if (ifc.done) done_cnt++;
      nd = 1'b0;
      if (m_valid && ifc.res_valid) begin
        chk("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("res_data", ifc.res_data, e.data);
          chk("res_ptr", ifc.res_ptr, e.ptr);
          chk("res_err", ifc.res_err, e.err);
        end
      end
      if (!m_busy && ifc.start) begin
        if (ifc.count == '0) nd = 1'b1;
        else begin
          for (int unsigned i = 0; i < 32'(ifc.count); i++) begin
            exp_q.push_back(model(mem[(32'(ifc.first_ptr) + i) % 32],
                                  address_t'((32'(ifc.first_ptr) + i) % 32)));
          end
          m_busy = 1'b1;
          m_cd   = 3;
        end
      end
      if (m_valid && ifc.res_valid && ifc.res_ready) begin
        log_q.push_back('{ifc.res_data, ifc.res_ptr, ifc.res_err});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_valid = 1'b0;
        if (exp_q.size() == 0) begin
          nd = 1'b1;
          m_busy = 1'b0;
        end else m_cd = 3;
      end
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input address_t fp, input int unsigned n);
    ifc.first_ptr = fp;
    ifc.count     = 6'(n);
    ifc.start     = 1'b1;
    step();
    ifc.start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int unsigned k;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      step();
      k++;
    end
    chk({name, "_done_seen"}, done_cnt > d0, 1);
  endtask

  task automatic wait_valid(input string name);
    int unsigned k;
    k = 0;
    while (!ifc.res_valid && k < 30) begin
      step();
      k++;
    end
    chk({name, "_valid_seen"}, ifc.res_valid, 1);
  endtask

  task automatic run_one(input address_t p, input instruction_t iw, input string name,
                         output res_t r);
    int d0;
    mem[p] = iw;
    log_q.delete();
    d0 = done_cnt;
    start_run(p, 1);
    wait_done(d0, name);
    chk({name, "_count"}, log_q.size(), 1);
    r = (log_q.size() > 0) ? log_q[0] : '{64'sd77, 5'd31, 1'b0};
  endtask

  res_t         r;
  instruction_t bad_iw;
  int           d0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ifc.start = 1'b0; ifc.first_ptr = '0; ifc.count = '0; ifc.res_ready = 1'b1;
    step(); step();
    chk("reset_rp", ifc.read_pointer, 0);
    chk("reset_ptr", ifc.res_ptr, 0);
    chk("reset_err", ifc.res_err, 0);
    reset_n = 1'b1;
    step();

    // Single ADD: latency and done timing pinned by hand.
    mem[0] = '{ADD, 32'sd5, -32'sd7};
    start_run(0, 1);
    chk("t1_busy", ifc.busy, 1);
    step();
    chk("t1_valid_e1", ifc.res_valid, 0);
    step();
    chk("t1_valid_e2", ifc.res_valid, 1);
    chk("t1_data", ifc.res_data, -2);
    chk("t1_ptr", ifc.res_ptr, 0);
    chk("t1_err", ifc.res_err, 0);
    step();
    chk("t1_done", ifc.done, 1);
    chk("t1_busy_done", ifc.busy, 0);
    step();
    chk("t1_done_off", ifc.done, 0);

    // Wrap-around run 30, 31, 0.
    mem[30] = '{MULT, 32'sh7FFFFFFF, 32'sd2};
    mem[31] = '{SUB, -32'sd1, 32'sd1};
    mem[0]  = '{PASSB, 32'sd0, 32'sd9};
    log_q.delete();
    d0 = done_cnt;
    start_run(30, 3);
    wait_done(d0, "t2");
    chk("t2_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t2_d0", log_q[0].data, 64'sh00000000FFFFFFFE);
      chk("t2_d1", log_q[1].data, -2);
      chk("t2_d2", log_q[2].data, 9);
      chk("t2_p0", log_q[0].ptr, 30);
      chk("t2_p1", log_q[1].ptr, 31);
      chk("t2_p2", log_q[2].ptr, 0);
    end

    // Division, modulo, errors and extra opcodes on entry 4.
    run_one(4, '{DIV, -32'sd7, 32'sd2}, "t3_div", r);
`ifdef INSTR_DIV_EN
    chk("t3_div_data", r.data, -3);  chk("t3_div_err", r.err, 0);
`else
    chk("t3_div_data", r.data, 0);   chk("t3_div_err", r.err, 1);
`endif
    run_one(4, '{MOD, -32'sd7, 32'sd2}, "t3_mod", r);
`ifdef INSTR_DIV_EN
    chk("t3_mod_data", r.data, -1);  chk("t3_mod_err", r.err, 0);
`else
    chk("t3_mod_data", r.data, 0);   chk("t3_mod_err", r.err, 1);
`endif
    run_one(4, '{DIV, 32'sd3, 32'sd0}, "t3_dz", r);
    chk("t3_dz_data", r.data, 0);    chk("t3_dz_err", r.err, 1);
    bad_iw = '{ZERO, 32'sd1, 32'sd2};
    bad_iw.opc = opcode_t'(4'hF);
    run_one(4, bad_iw, "t3_ill", r);
    chk("t3_ill_data", r.data, 0);   chk("t3_ill_err", r.err, 1);
    run_one(4, '{MULT, -32'sd2, 32'sd3}, "t3_mul", r);
    chk("t3_mul_data", r.data, -6);  chk("t3_mul_err", r.err, 0);
    run_one(4, '{PASSA, -32'sd8, 32'sd3}, "t3_pa", r);
    chk("t3_pa_data", r.data, -8);

    // Back-pressure: hold for 5 cycles, then one transfer.
    mem[10] = '{ADD, 32'sd100, 32'sd23};
    mem[11] = '{PASSA, -32'sd5, 32'sd0};
    ifc.res_ready = 1'b0;
    log_q.delete();
    d0 = done_cnt;
    start_run(10, 2);
    wait_valid("t4a");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", ifc.res_valid, 1);
      chk("t4_hold_data", ifc.res_data, 123);
      chk("t4_hold_ptr", ifc.res_ptr, 10);
      chk("t4_hold_err", ifc.res_err, 0);
      step();
    end
    ifc.res_ready = 1'b1;
    step();
    ifc.res_ready = 1'b0;
    chk("t4_one_xfer", log_q.size(), 1);
    wait_valid("t4b");
    chk("t4_still_one", log_q.size(), 1);
    chk("t4_second_data", ifc.res_data, -5);
    chk("t4_second_ptr", ifc.res_ptr, 11);
    ifc.res_ready = 1'b1;
    wait_done(d0, "t4");
    chk("t4_count", log_q.size(), 2);

    // Zero-length run, then start ignored while busy.
    d0 = done_cnt;
    start_run(5, 0);
    chk("t5_zero_done", ifc.done, 1);
    chk("t5_zero_busy", ifc.busy, 0);
    step();
    chk("t5_zero_done_off", ifc.done, 0);
    chk("t5_zero_busy_off", ifc.busy, 0);
    chk("t5_zero_cnt", done_cnt, d0 + 1);
    log_q.delete();
    d0 = done_cnt;
    start_run(10, 2);
    step();
    ifc.first_ptr = 5'd0; ifc.count = 6'd5; ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    wait_done(d0, "t5");
    chk("t5_len", log_q.size(), 2);
    if (log_q.size() == 2) chk("t5_last_ptr", log_q[1].ptr, 11);
    step();
    chk("t5_idle", ifc.busy, 0);

    // Reset during EXEC of a 4-entry run.
    mem[0] = '{ADD, 32'sd1, 32'sd2};
    mem[1] = '{SUB, 32'sd10, 32'sd3};
    mem[2] = '{MULT, -32'sd4, 32'sd5};
    mem[3] = '{ZERO, 32'sd6, 32'sd6};
    log_q.delete();
    d0 = done_cnt;
    start_run(0, 4);
    step();
    reset_n = 1'b0;
    #1;
    chk("t6_valid", ifc.res_valid, 0);
    chk("t6_data", ifc.res_data, 0);
    chk("t6_ptr", ifc.res_ptr, 0);
    chk("t6_err", ifc.res_err, 0);
    chk("t6_busy", ifc.busy, 0);
    chk("t6_done", ifc.done, 0);
    chk("t6_rp", ifc.read_pointer, 0);
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    chk("t6_no_done", done_cnt, d0);
    chk("t6_no_result", log_q.size(), 0);
    start_run(0, 4);
    wait_done(d0, "t6");
    chk("t6_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t6_d0", log_q[0].data, 3);
      chk("t6_d1", log_q[1].data, 7);
      chk("t6_d2", log_q[2].data, -20);
      chk("t6_d3", log_q[3].data, 0);
      chk("t6_p3", log_q[3].ptr, 3);
    end
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
